// File: rtl/rv_alu_pipe.sv
// Integer ALU pipeline: instruction queue -> decode/read (D) -> execute result (X) -> GPR writeback.
// Latency: accepted at edge k, in D at k+1, in X at k+2, GPR written and retired at k+3; one per cycle.
// Backpressure: in_ready = queue not full; hold freezes D/X, and a RAW hazard stalls D when FWD_EN=0.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   in_valid/in_ready/in_instr instruction intake handshake
//   hold                       freeze D and X (queue keeps accepting until full)
//   dbg_raddr/dbg_rdata        combinational GPR debug read (0 for x0 or out-of-range index)
//   retired_cnt                legal instructions written back (wraps)
//   illegal/illegal_instr      pulse and held word for an illegal instruction leaving D
//   iq_count, busy             queue occupancy and pipeline-activity status
module rv_alu_pipe #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int IQ_DEPTH = 4,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic                      hold,
  input  logic [4:0]                dbg_raddr,
  output logic [XLEN-1:0]           dbg_rdata,
  output logic [CNT_W-1:0]          retired_cnt,
  output logic                      illegal,
  output logic [31:0]               illegal_instr,
  output logic [$clog2(IQ_DEPTH):0] iq_count,
  output logic                      busy
);

  localparam int PW  = $clog2(IQ_DEPTH);
  localparam int CW  = PW + 1;
  localparam int SHW = $clog2(XLEN);
  localparam int RW  = $clog2(NREGS);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND, OP_LUI
  } alu_op_t;

  // ---------------- instruction queue ----------------
  logic [31:0]   q_mem [IQ_DEPTH];
  logic [PW-1:0] q_wr;
  logic [PW-1:0] q_rd;
  logic [CW-1:0] q_cnt;
  logic          push;
  logic          pop;
  logic          q_empty;

  // ---------------- pipeline state ----------------
  logic [XLEN-1:0] gpr [NREGS];
  logic            d_vld;
  logic [31:0]     d_instr;
  logic            x_vld;
  logic [4:0]      x_rd;
  logic [XLEN-1:0] x_res;

  assign in_ready = (q_cnt != CW'(IQ_DEPTH));
  assign push     = in_valid & in_ready;
  assign q_empty  = (q_cnt == '0);
  assign iq_count = q_cnt;
  assign busy     = !q_empty || d_vld || x_vld;

  function automatic logic reg_ok(input logic [4:0] r);
    return {1'b0, r} < 6'(NREGS);
  endfunction

  function automatic logic [XLEN-1:0] rd_gpr(input logic [4:0] r);
    if (r == 5'd0 || !reg_ok(r)) return '0;
    return gpr[r[RW-1:0]];
  endfunction

  // ---------------- decode ----------------
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            sh_zero;
  logic            sh_sra;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] lui_imm;
  alu_op_t         op;
  logic            use_rs1;
  logic            use_rs2;
  logic            use_imm;
  logic            dec_ok;
  logic            d_legal;

  assign opc = d_instr[6:0];
  assign rd  = d_instr[11:7];
  assign f3  = d_instr[14:12];
  assign rs1 = d_instr[19:15];
  assign rs2 = d_instr[24:20];
  assign f7  = d_instr[31:25];

  // RV64 immediate shifts borrow inst[25] as the top shamt bit, so only inst[31:26] is funct.
  assign sh_zero = (XLEN == 64) ? (d_instr[31:26] == 6'b000000) : (d_instr[31:25] == 7'b0000000);
  assign sh_sra  = (XLEN == 64) ? (d_instr[31:26] == 6'b010000) : (d_instr[31:25] == 7'b0100000);

  assign imm     = XLEN'($signed(d_instr[31:20]));
  assign lui_imm = XLEN'($signed({d_instr[31:12], 12'h000}));

  always_comb begin
    op      = OP_ADD;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_imm = 1'b0;
    dec_ok  = 1'b0;
    case (opc)
      7'b0110011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_ok  = 1'b1;
        case ({f7, f3})
          {7'b0000000, 3'b000}: op = OP_ADD;
          {7'b0100000, 3'b000}: op = OP_SUB;
          {7'b0000000, 3'b001}: op = OP_SLL;
          {7'b0000000, 3'b010}: op = OP_SLT;
          {7'b0000000, 3'b011}: op = OP_SLTU;
          {7'b0000000, 3'b100}: op = OP_XOR;
          {7'b0000000, 3'b101}: op = OP_SRL;
          {7'b0100000, 3'b101}: op = OP_SRA;
          {7'b0000000, 3'b110}: op = OP_OR;
          {7'b0000000, 3'b111}: op = OP_AND;
          default:              dec_ok = 1'b0;
        endcase
      end
      7'b0010011: begin
        use_rs1 = 1'b1;
        use_imm = 1'b1;
        dec_ok  = 1'b1;
        case (f3)
          3'b000: op = OP_ADD;
          3'b010: op = OP_SLT;
          3'b011: op = OP_SLTU;
          3'b100: op = OP_XOR;
          3'b110: op = OP_OR;
          3'b111: op = OP_AND;
          3'b001: begin
            op     = OP_SLL;
            dec_ok = sh_zero;
          end
          3'b101: begin
            op     = sh_sra ? OP_SRA : OP_SRL;
            dec_ok = sh_zero || sh_sra;
          end
        endcase
      end
      7'b0110111: begin
        op     = OP_LUI;
        dec_ok = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  assign d_legal = dec_ok && reg_ok(rd)
                && (!use_rs1 || reg_ok(rs1))
                && (!use_rs2 || reg_ok(rs2));

  // ---------------- operands, hazard, ALU ----------------
  logic            fwd1;
  logic            fwd2;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb_reg;
  logic [XLEN-1:0] opb;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            raw;
  logic            stall;
  logic            d_leave;

  assign fwd1    = (FWD_EN != 0) && x_vld && (x_rd == rs1) && (rs1 != 5'd0);
  assign fwd2    = (FWD_EN != 0) && x_vld && (x_rd == rs2) && (rs2 != 5'd0);
  assign opa     = fwd1 ? x_res : rd_gpr(rs1);
  assign opb_reg = fwd2 ? x_res : rd_gpr(rs2);
  assign opb     = use_imm ? imm : opb_reg;
  assign shamt   = opb[SHW-1:0];

  // Without forwarding, X's value lands in the GPR file at the edge that holds D,
  // so a single bubble is always enough.
  assign raw   = x_vld && (x_rd != 5'd0)
              && ((use_rs1 && x_rd == rs1) || (use_rs2 && x_rd == rs2));
  assign stall = (FWD_EN == 0) && d_vld && d_legal && raw;

  assign d_leave = d_vld && !hold && !stall;
  assign pop     = !hold && !q_empty && (!d_vld || d_leave);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_SLL:  alu_res = opa << shamt;
      OP_SLT:  alu_res = XLEN'($signed(opa) < $signed(opb));
      OP_SLTU: alu_res = XLEN'(opa < opb);
      OP_XOR:  alu_res = opa ^ opb;
      OP_SRL:  alu_res = opa >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(opa) >>> shamt);
      OP_OR:   alu_res = opa | opb;
      OP_AND:  alu_res = opa & opb;
      OP_LUI:  alu_res = lui_imm;
      default: alu_res = '0;
    endcase
  end

  assign dbg_rdata = rd_gpr(dbg_raddr);

  // ---------------- sequential ----------------
  always_ff @(posedge clk) begin
    if (push) q_mem[q_wr] <= in_instr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_wr          <= '0;
      q_rd          <= '0;
      q_cnt         <= '0;
      d_vld         <= 1'b0;
      d_instr       <= '0;
      x_vld         <= 1'b0;
      x_rd          <= '0;
      x_res         <= '0;
      retired_cnt   <= '0;
      illegal       <= 1'b0;
      illegal_instr <= '0;
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
    end else begin
      if (push) q_wr <= q_wr + 1'b1;
      if (pop) begin
        q_rd    <= q_rd + 1'b1;
        d_instr <= q_mem[q_rd];
      end
      q_cnt <= q_cnt + CW'(push) - CW'(pop);

      if (pop)          d_vld <= 1'b1;
      else if (d_leave) d_vld <= 1'b0;

      // An illegal word leaves D as a bubble; only the report survives.
      illegal <= d_leave && !d_legal;
      if (d_leave && !d_legal) illegal_instr <= d_instr;

      if (!hold) begin
        x_vld <= d_leave && d_legal;
        x_rd  <= rd;
        x_res <= alu_res;
        if (x_vld) begin
          retired_cnt <= retired_cnt + 1'b1;
          if (x_rd != 5'd0) gpr[x_rd[RW-1:0]] <= x_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_alu_pipe.sv
// Directed bench: three pipelines (forwarding, stall-on-hazard, 16-register) share one stimulus stream.
// Latency: checks are sampled 1 time unit after each rising edge.
// Backpressure: the hold/full-queue sequence checks in_ready and that the overflow word is dropped.
module tb_rv_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        hold;
  logic [4:0]  dbg_raddr;

  logic        rdy_m, rdy_n, rdy_e;
  logic [31:0] dbg_m, dbg_n, dbg_e;
  logic [31:0] cnt_m, cnt_n, cnt_e;
  logic        ill_m, ill_n, ill_e;
  logic [31:0] illw_m, illw_n, illw_e;
  logic [2:0]  iq_m, iq_n, iq_e;
  logic        busy_m, busy_n, busy_e;

  always #5 clk = ~clk;

  rv_alu_pipe #(.FWD_EN(1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_m), .in_instr(in_instr),
    .hold(hold), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_m), .retired_cnt(cnt_m),
    .illegal(ill_m), .illegal_instr(illw_m), .iq_count(iq_m), .busy(busy_m));

  rv_alu_pipe #(.FWD_EN(0)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_n), .in_instr(in_instr),
    .hold(hold), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_n), .retired_cnt(cnt_n),
    .illegal(ill_n), .illegal_instr(illw_n), .iq_count(iq_n), .busy(busy_n));

  rv_alu_pipe #(.NREGS(16)) dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_e), .in_instr(in_instr),
    .hold(hold), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_e), .retired_cnt(cnt_e),
    .illegal(ill_e), .illegal_instr(illw_e), .iq_count(iq_e), .busy(busy_e));

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_m = 0;  // expected retired count for dut_m and dut_n
  logic [31:0] exp_e = 0;  // expected retired count for dut_e

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[22];

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] lui(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic chk_reg(input string name, input logic [4:0] r, input logic [31:0] em,
                         input logic [31:0] en, input logic [31:0] ee);
    dbg_raddr = r;
    #1;
    chk({name, "/fwd"}, dbg_m, em);
    chk({name, "/stall"}, dbg_n, en);
    chk({name, "/rv32e"}, dbg_e, ee);
  endtask

  task automatic chk_cnt(input string name);
    chk({name, "/fwd"}, cnt_m, exp_m);
    chk({name, "/stall"}, cnt_n, exp_m);
    chk({name, "/rv32e"}, cnt_e, exp_e);
  endtask

  task automatic drain();
    int n = 0;
    while ((busy_m || busy_n || busy_e) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_idle", {29'd0, busy_m, busy_n, busy_e}, 32'd0);
  endtask

  task automatic push1(input logic [31:0] w);
    in_valid = 1'b1;
    in_instr = w;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; hold = 1'b0; dbg_raddr = '0;

    tbl[0]  = '{i_t(12'h404, 5'd3, 3'b101, 5'd4), 5'd4, 32'hF8000000, "srai"};
    tbl[1]  = '{i_t(12'h004, 5'd3, 3'b101, 5'd4), 5'd4, 32'h08000000, "srli"};
    tbl[2]  = '{i_t(12'hFFF, 5'd3, 3'b010, 5'd5), 5'd5, 32'h00000001, "slti_neg"};
    tbl[3]  = '{i_t(12'hFFF, 5'd0, 3'b011, 5'd5), 5'd5, 32'h00000001, "sltiu_max"};
    tbl[4]  = '{r_t(7'h00, 5'd7, 5'd6, 3'b000, 5'd9), 5'd9, 32'hFFFFFFFC, "add"};
    tbl[5]  = '{r_t(7'h20, 5'd6, 5'd7, 3'b000, 5'd9), 5'd9, 32'h0000000A, "sub"};
    tbl[6]  = '{r_t(7'h00, 5'd7, 5'd7, 3'b001, 5'd9), 5'd9, 32'h00000018, "sll"};
    tbl[7]  = '{r_t(7'h00, 5'd7, 5'd6, 3'b010, 5'd9), 5'd9, 32'h00000001, "slt"};
    tbl[8]  = '{r_t(7'h00, 5'd7, 5'd6, 3'b011, 5'd9), 5'd9, 32'h00000000, "sltu"};
    tbl[9]  = '{r_t(7'h00, 5'd7, 5'd8, 3'b100, 5'd9), 5'd9, 32'h000000F3, "xor"};
    tbl[10] = '{r_t(7'h00, 5'd7, 5'd6, 3'b101, 5'd9), 5'd9, 32'h1FFFFFFF, "srl"};
    tbl[11] = '{r_t(7'h20, 5'd7, 5'd6, 3'b101, 5'd9), 5'd9, 32'hFFFFFFFF, "sra"};
    tbl[12] = '{r_t(7'h00, 5'd7, 5'd8, 3'b110, 5'd9), 5'd9, 32'h000000F3, "or"};
    tbl[13] = '{r_t(7'h00, 5'd6, 5'd8, 3'b111, 5'd9), 5'd9, 32'h000000F0, "and"};
    tbl[14] = '{i_t(12'hFFF, 5'd8, 3'b100, 5'd9), 5'd9, 32'hFFFFFF0F, "xori"};
    tbl[15] = '{i_t(12'h100, 5'd7, 3'b110, 5'd9), 5'd9, 32'h00000103, "ori"};
    tbl[16] = '{i_t(12'h0FF, 5'd6, 3'b111, 5'd9), 5'd9, 32'h000000F9, "andi"};
    tbl[17] = '{i_t(12'h01F, 5'd7, 3'b001, 5'd9), 5'd9, 32'h80000000, "slli31"};
    tbl[18] = '{lui(20'hABCDE, 5'd9), 5'd9, 32'hABCDE000, "lui"};
    tbl[19] = '{r_t(7'h00, 5'd3, 5'd3, 3'b000, 5'd9), 5'd9, 32'h00000000, "add_wrap"};
    tbl[20] = '{i_t(12'h004, 5'd7, 3'b010, 5'd9), 5'd9, 32'h00000001, "slti_pos"};
    tbl[21] = '{i_t(12'h800, 5'd0, 3'b000, 5'd9), 5'd9, 32'hFFFFF800, "addi_min"};

    tick();
    tick();
    // Reset state
    chk("rst_busy", {29'd0, busy_m, busy_n, busy_e}, 32'd0);
    chk("rst_ready", {29'd0, rdy_m, rdy_n, rdy_e}, 32'd7);
    chk("rst_iq", 32'(iq_m), 32'd0);
    chk("rst_cnt", cnt_m, 32'd0);
    chk("rst_illegal", {31'd0, ill_m}, 32'd0);
    chk("rst_illw", illw_m, 32'd0);
    rst = 1'b0;
    chk_reg("rst_x1", 5'd1, 32'd0, 32'd0, 32'd0);

    // Back-to-back dependent pair: forwarding vs one-cycle stall
    in_valid = 1'b1;
    in_instr = i_t(12'd5, 5'd0, 3'b000, 5'd1);
    tick();                                          // edge k
    in_instr = r_t(7'h00, 5'd1, 5'd1, 3'b000, 5'd2);
    tick();                                          // edge k+1
    in_valid = 1'b0;
    tick();                                          // k+2
    chk("t1_cnt_k2", cnt_m, 32'd0);
    tick();                                          // k+3
    chk("t1_cnt_k3_fwd", cnt_m, 32'd1);
    chk("t1_cnt_k3_stall", cnt_n, 32'd1);
    tick();                                          // k+4
    chk("t1_cnt_k4_fwd", cnt_m, 32'd2);
    chk("t1_cnt_k4_stall", cnt_n, 32'd1);
    tick();                                          // k+5
    chk("t1_cnt_k5_stall", cnt_n, 32'd2);
    exp_m = 2; exp_e = 2;
    drain();
    chk_reg("t1_x2", 5'd2, 32'd10, 32'd10, 32'd10);

    // Operand setup, streamed back to back
    in_valid = 1'b1;
    in_instr = lui(20'h80000, 5'd3);          tick();
    in_instr = i_t(12'hFF9, 5'd0, 3'b000, 5'd6); tick();
    in_instr = i_t(12'h003, 5'd0, 3'b000, 5'd7); tick();
    in_instr = i_t(12'h0F0, 5'd0, 3'b000, 5'd8); tick();
    in_valid = 1'b0;
    exp_m += 4; exp_e += 4;
    drain();
    chk_reg("pre_x3", 5'd3, 32'h80000000, 32'h80000000, 32'h80000000);
    chk_reg("pre_x6", 5'd6, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9);

    // ALU vector table
    for (int i = 0; i < 22; i++) begin
      push1(tbl[i].instr);
      exp_m++; exp_e++;
      drain();
      chk_reg(tbl[i].name, tbl[i].rd, tbl[i].exp, tbl[i].exp, tbl[i].exp);
    end
    chk_cnt("table_cnt");

    // hold freezes an instruction sitting in X
    push1(i_t(12'd33, 5'd0, 3'b000, 5'd15));       // edge k
    tick();                                        // k+1: D
    tick();                                        // k+2: X
    hold = 1'b1;
    tick(); tick(); tick();
    chk_reg("hold_x15_frozen", 5'd15, 32'd0, 32'd0, 32'd0);
    chk_cnt("hold_cnt_frozen");
    chk("hold_busy", {31'd0, busy_m}, 32'd1);
    hold = 1'b0;
    tick();
    exp_m++; exp_e++;
    chk_reg("hold_x15_released", 5'd15, 32'd33, 32'd33, 32'd33);
    chk_cnt("hold_cnt_released");

    // Fill queue under hold; fifth word must be dropped
    hold = 1'b1;
    in_valid = 1'b1;
    in_instr = i_t(12'd1, 5'd0, 3'b000, 5'd10);          tick();
    in_instr = i_t(12'd1, 5'd10, 3'b000, 5'd11);         tick();
    in_instr = i_t(12'd1, 5'd11, 3'b000, 5'd12);         tick();
    in_instr = r_t(7'h00, 5'd11, 5'd12, 3'b000, 5'd13);  tick();
    chk("full_ready", {29'd0, rdy_m, rdy_n, rdy_e}, 32'd0);
    in_instr = i_t(12'd9, 5'd0, 3'b000, 5'd14);          tick();
    in_valid = 1'b0;
    chk("full_iq", 32'(iq_m), 32'd4);
    chk("full_iq_stall", 32'(iq_n), 32'd4);
    hold = 1'b0;
    exp_m += 4; exp_e += 4;
    drain();
    chk_reg("q_x10", 5'd10, 32'd1, 32'd1, 32'd1);
    chk_reg("q_x12", 5'd12, 32'd3, 32'd3, 32'd3);
    chk_reg("q_x13", 5'd13, 32'd5, 32'd5, 32'd5);
    chk_reg("q_x14_dropped", 5'd14, 32'd0, 32'd0, 32'd0);
    chk_cnt("q_cnt");

    // Illegal words followed by a discarded write to x0
    in_valid = 1'b1;
    in_instr = 32'hFFFFFFFF;                       tick();  // k
    in_instr = 32'h00000000;                       tick();  // k+1
    in_instr = i_t(12'd7, 5'd0, 3'b000, 5'd0);     tick();  // k+2
    in_valid = 1'b0;
    chk("ill1_pulse", {29'd0, ill_m, ill_n, ill_e}, 32'd7);
    chk("ill1_word", illw_m, 32'hFFFFFFFF);
    tick();                                                 // k+3
    chk("ill0_pulse", {29'd0, ill_m, ill_n, ill_e}, 32'd7);
    chk("ill0_word", illw_m, 32'h00000000);
    tick();                                                 // k+4
    chk("ill_end", {29'd0, ill_m, ill_n, ill_e}, 32'd0);
    chk("ill_word_held", illw_e, 32'h00000000);
    exp_m++; exp_e++;
    drain();
    chk_reg("x0_zero", 5'd0, 32'd0, 32'd0, 32'd0);
    chk_cnt("ill_cnt");

    // Register index beyond NREGS on the 16-register build
    in_valid = 1'b1;
    in_instr = r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd17);    tick();  // k
    in_instr = i_t(12'd1, 5'd20, 3'b000, 5'd4);          tick();  // k+1
    in_valid = 1'b0;
    tick();                                                       // k+2
    chk("e_rd17_pulse", {30'd0, ill_m, ill_e}, 32'd1);
    chk("e_rd17_word", illw_e, r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd17));
    tick();                                                       // k+3
    chk("e_rs20_pulse", {30'd0, ill_m, ill_e}, 32'd1);
    chk("e_rs20_word", illw_e, i_t(12'd1, 5'd20, 3'b000, 5'd4));
    exp_m += 2;
    drain();
    chk_reg("e_x17", 5'd17, 32'd15, 32'd15, 32'd0);
    chk_reg("e_x4", 5'd4, 32'd1, 32'd1, 32'h08000000);
    chk_cnt("e_cnt");

    // Reset with instructions in flight and a handshake at the reset edge
    in_valid = 1'b1;
    in_instr = i_t(12'd1, 5'd0, 3'b000, 5'd21); tick();
    in_instr = i_t(12'd2, 5'd0, 3'b000, 5'd22); tick();
    in_instr = i_t(12'd3, 5'd0, 3'b000, 5'd23); tick();
    in_instr = i_t(12'd4, 5'd0, 3'b000, 5'd24);
    rst = 1'b1;
    tick();
    chk("rr_busy", {29'd0, busy_m, busy_n, busy_e}, 32'd0);
    chk("rr_iq", {23'd0, iq_m, iq_n, iq_e}, 32'd0);
    exp_m = 0; exp_e = 0;
    chk_cnt("rr_cnt");
    chk_reg("rr_x21", 5'd21, 32'd0, 32'd0, 32'd0);
    chk_reg("rr_x2", 5'd2, 32'd0, 32'd0, 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("rr_busy_after", {29'd0, busy_m, busy_n, busy_e}, 32'd0);
    chk_reg("rr_x24", 5'd24, 32'd0, 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
